// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl_pkg
// Purpose  : Shared types and constants for the nibble-serial adder
//            sequencer. These are the FSM state encoding and the slice width.
// Revision : 1.0 - initial release
// ============================================================================
package adder_ctrl_pkg;

  // Width of one adder slice. One nibble is processed per cycle.
  localparam int NIB_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : adder_ctrl_pkg
`default_nettype wire

// File: rtl/four_bit_adder.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_adder
// Purpose  : 4-bit adder slice with carry-in and carry-out. This is the only
//            arithmetic resource used by the nibble-serial sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_adder
  import adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c_o
);

  // Widen by one bit so that the carry-out is kept in the MSB of the sum.
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, c_i};

endmodule : four_bit_adder
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Adds two WIDTH-bit operands through a single 4-bit adder slice,
//            one nibble per cycle with the LSB nibble first. The carry is held
//            in a register between nibbles. Both sides use a valid/ready
//            handshake.
// Config   : `define SIGNED_OVF_EN adds the 'ovf' output, which reports
//            two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef SIGNED_OVF_EN
  , output logic           ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  // Stop elaboration if the operand width cannot be split into at least two nibbles.
  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_sh_q, a_sh_d;
  logic [WIDTH-1:0]       b_sh_q, b_sh_d;
  // Holds the nibbles finished so far. The nibble in progress is
  // concatenated on top to form the full result.
  logic [WIDTH-NIB_W-1:0] sum_sh_q, sum_sh_d;
  logic                   carry_q, carry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  // The result registers are separate from the shift path so that the last
  // result stays visible while the next job runs.
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic                   cout_q, cout_d;
`ifdef SIGNED_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0]       w_slice_s;
  logic                   w_slice_c;
  logic [WIDTH-1:0]       w_sum_cat;

  four_bit_adder u_slice (
    .a_i (a_sh_q[NIB_W-1:0]),
    .b_i (b_sh_q[NIB_W-1:0]),
    .c_i (carry_q),
    .s_o (w_slice_s),
    .c_o (w_slice_c)
  );

  assign w_sum_cat = {w_slice_s, sum_sh_q};

  // State and datapath registers. Reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic and handshake outputs for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        a_sh_d   = {{NIB_W{1'b0}}, a_sh_q[WIDTH-1:NIB_W]};
        b_sh_d   = {{NIB_W{1'b0}}, b_sh_q[WIDTH-1:NIB_W]};
        sum_sh_d = w_sum_cat[WIDTH-1:NIB_W];
        carry_d  = w_slice_c;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          // Last nibble. Publish the full result and its final carry.
          sum_d   = w_sum_cat;
          cout_d  = w_slice_c;
`ifdef SIGNED_OVF_EN
          // The carry into the MSB is recovered from the sum bit of the top slice.
          ovf_d   = (a_sh_q[NIB_W-1] ^ b_sh_q[NIB_W-1] ^ w_slice_s[NIB_W-1]) ^ w_slice_c;
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef SIGNED_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule : nibble_serial_adder_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Self-checking bench for nibble_serial_adder_ctrl. The directed
//            steps run on a WIDTH=16 instance. Random jobs run on a WIDTH=32
//            instance and are compared against plain a+b+c_in arithmetic.
// Config   : honours `define SIGNED_OVF_EN (checks the ovf output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // WIDTH=16 instance signals
  logic        iv16 = 1'b0, or16 = 1'b0, ci16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, co16, bz16;
  logic [15:0] s16;
  // WIDTH=32 instance signals
  logic        iv32 = 1'b0, or32 = 1'b0, ci32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, co32, bz32;
  logic [31:0] s32;
`ifdef SIGNED_OVF_EN
  logic        of16, of32;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .c_in(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16), .busy(bz16)
`ifdef SIGNED_OVF_EN
    , .ovf(of16)
`endif
  );

  nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .c_in(ci32), .out_valid(ov32), .out_ready(or32), .sum(s32), .c_out(co32), .busy(bz32)
`ifdef SIGNED_OVF_EN
    , .ovf(of32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed overflow of a+b+cin: operands share a sign and the result sign differs.
  function automatic logic ovf_ref(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  // Presents one job to the 16-bit instance and returns the cycles until out_valid.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output int lat);
    int k;
    @(negedge clk);
    chk("ready16_before_accept", 64'(ir16), 64'd1);
    a16 = a; b16 = b; ci16 = ci; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    k = 1;
    while (!ov16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k - 1;
  endtask

  // Runs one 16-bit job and checks the result against plain arithmetic.
  task automatic job16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci);
    int          lat;
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    start16(a, b, ci, lat);
    chk({tag, "_lat"},  64'(lat),  64'd4);
    chk({tag, "_sum"},  64'(s16),  64'(r[15:0]));
    chk({tag, "_cout"}, 64'(co16), 64'(r[16]));
`ifdef SIGNED_OVF_EN
    chk({tag, "_ovf"},  64'(of16), 64'(ovf_ref(a[15], b[15], r[15])));
`endif
  endtask

  task automatic handoff16();
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk("handoff16_valid_low", 64'(ov16), 64'd0);
  endtask

  initial begin
    int          lat, k, gap;
    logic        r;
    logic [31:0] ea, eb;
    logic        eci;
    logic [32:0] er;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(ir16), 64'd1);
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_busy",      64'(bz16), 64'd0);
    chk("rst_sum",       64'(s16),  64'd0);
    chk("rst_cout",      64'(co16), 64'd0);
`ifdef SIGNED_OVF_EN
    chk("rst_ovf",       64'(of16), 64'd0);
`endif
    rst_n = 1'b1;

    // Directed arithmetic cases
    job16("j1234", 16'h1234, 16'h4321, 1'b0);
    chk("j1234_const_sum", 64'(s16), 64'h5555);
    handoff16();
    job16("jripple", 16'hFFFF, 16'h0001, 1'b0);
    chk("jripple_const", 64'({co16, s16}), 64'h10000);
    handoff16();
    job16("j7fff", 16'h7FFF, 16'h0001, 1'b0);
    chk("j7fff_const", 64'({co16, s16}), 64'h08000);
    handoff16();
    job16("jffff", 16'hFFFF, 16'hFFFF, 1'b0);
    handoff16();
    job16("jcin", 16'h7FFF, 16'h0000, 1'b1);
    handoff16();

    // Result held with out_ready low; new in_valid ignored while DONE
    job16("jhold", 16'hABCD, 16'h1111, 1'b1);
    a16 = 16'h0101; b16 = 16'h0202; iv16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(ov16), 64'd1);
      chk("hold_sum",   64'(s16),  64'hBCDF);
      chk("hold_cout",  64'(co16), 64'd0);
      chk("hold_ready", 64'(ir16), 64'd0);
    end
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    iv16 = 1'b0;
    chk("after_hold_valid", 64'(ov16), 64'd0);
    chk("after_hold_busy",  64'(bz16), 64'd0);
    chk("after_hold_ready", 64'(ir16), 64'd1);
    chk("after_hold_sum",   64'(s16),  64'hBCDF);

    // Reset while RUN with idx=2
    @(negedge clk);
    a16 = 16'h2222; b16 = 16'h3333; ci16 = 1'b0; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(bz16), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ir16), 64'd1);
    chk("abort_valid", 64'(ov16), 64'd0);
    chk("abort_sum",   64'(s16),  64'd0);
    chk("abort_busy",  64'(bz16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    job16("jpost", 16'h0F0F, 16'h00F1, 1'b0);
    chk("jpost_const", 64'(s16), 64'h1000);
    handoff16();

    // Random jobs on the 32-bit instance with random in_valid/out_ready
    for (int j = 0; j < 1000; j++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; or32 = 1'($urandom);
      end
      @(negedge clk);
      ea = $urandom; eb = $urandom; eci = 1'($urandom);
      er = {1'b0, ea} + {1'b0, eb} + {32'd0, eci};
      chk("r32_ready", 64'(ir32), 64'd1);
      a32 = ea; b32 = eb; ci32 = eci; iv32 = 1'b1; or32 = 1'($urandom);
      k = 0;
      while (k < 40) begin
        @(negedge clk);
        k++;
        if (ov32) break;
        // Operands are not captured outside IDLE, so garbage here must not matter.
        iv32 = 1'($urandom); a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
        or32 = 1'($urandom);
      end
      iv32 = 1'b0;
      chk("r32_lat",  64'(k - 1), 64'd8);
      chk("r32_sum",  64'(s32),   64'(er[31:0]));
      chk("r32_cout", 64'(co32),  64'(er[32]));
`ifdef SIGNED_OVF_EN
      chk("r32_ovf",  64'(of32),  64'(ovf_ref(ea[31], eb[31], er[31])));
`endif
      k = 0;
      do begin
        r = 1'($urandom);
        or32 = r;
        @(negedge clk);
        k++;
        if (!r) chk("r32_held", 64'({ov32, co32, s32}), 64'({1'b1, er}));
      end while (!r && k < 40);
      or32 = 1'b0;
      chk("r32_handoff", 64'(ov32), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_nibble_serial_adder_ctrl
`default_nettype wire
